// File: rtl/mult_arbiter.sv
// mult_arbiter
// ------------
// Round-robin arbiter that time-shares one external shift-add multiplier
// among N_REQ requesters. A granted requester's operands are latched, the
// multiplier is cleared, then loaded, and the arbiter waits for the sticky
// done flag. The product is returned to the same requester, which must
// accept it before the next grant can happen.
//
// Handshake semantics (both directions): a transfer happens on a rising
// clk edge where valid and ready are both high. req_ready is a one-hot
// strobe, asserted only in the IDLE grant cycle and combinationally derived
// from req_valid there. rsp_valid is registered and, once raised, stays high
// with rsp_q/rsp_err stable until the granted bit of rsp_ready is sampled
// high. rsp_ready bits of non-granted requesters are ignored.
//
// Optional feature: define MULT_ARB_TIMEOUT_EN to add a WAIT-state watchdog.
// After TIMEOUT WAIT cycles without mul_flag the operation ends with
// rsp_q=0, rsp_err=1. Without the macro, WAIT waits indefinitely and
// rsp_err is tied low.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   req_valid/req_ready per-requester request handshake (one-hot ready)
//   req_a, req_b        packed signed 16-bit operands, requester i at [16i+:16]
//   rsp_valid/rsp_ready per-requester result handshake (one-hot valid)
//   rsp_q, rsp_err      signed product and watchdog-abort flag
//   mul_a, mul_b        operands to the shared multiplier
//   mul_en, mul_rst     multiplier load enable and clear
//   mul_flag, mul_q     multiplier done flag (sticky) and product
//   o_dbg_state         current FSM state, for observation only
module mult_arbiter #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 40
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [16*N_REQ-1:0]  req_a,
    input  logic [16*N_REQ-1:0]  req_b,
    output logic [N_REQ-1:0]     req_ready,
    output logic [N_REQ-1:0]     rsp_valid,
    input  logic [N_REQ-1:0]     rsp_ready,
    output logic [31:0]          rsp_q,
    output logic                 rsp_err,
    output logic [15:0]          mul_a,
    output logic [15:0]          mul_b,
    output logic                 mul_en,
    output logic                 mul_rst,
    input  logic                 mul_flag,
    input  logic [31:0]          mul_q,
    output logic [2:0]           o_dbg_state
);
    localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CLR  = 3'd1,
        LOAD = 3'd2,
        WAIT = 3'd3,
        RESP = 3'd4
    } state_t;

    state_t            r_state;
    logic [GW-1:0]     r_last_grant;
    logic [GW-1:0]     r_grant;
    logic [15:0]       r_mul_a;
    logic [15:0]       r_mul_b;
    logic              r_mul_en;
    logic [N_REQ-1:0]  r_rsp_valid;
    logic [31:0]       r_rsp_q;

    logic              w_any;
    logic [GW-1:0]     w_pick;
    int                w_idx;
    logic [N_REQ-1:0]  w_grant_oh;

    // Search starts one past the last grant and wraps, so every requester
    // is reached within N_REQ grants.
    always_comb begin : rr_search
        w_any  = 1'b0;
        w_pick = '0;
        w_idx  = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            if (!w_any) begin
                w_idx = int'(r_last_grant) + k;
                if (w_idx >= N_REQ) w_idx = w_idx - N_REQ;
                if (req_valid[w_idx[GW-1:0]]) begin
                    w_any  = 1'b1;
                    w_pick = w_idx[GW-1:0];
                end
            end
        end
    end

    // Accept strobe is gated by rst so nothing is accepted while resetting.
    always_comb begin : accept_strobe
        req_ready = '0;
        if (r_state == IDLE && !rst && w_any) req_ready[w_pick] = 1'b1;
    end

    always_comb begin : grant_decode
        w_grant_oh          = '0;
        w_grant_oh[r_grant] = 1'b1;
    end

`ifdef MULT_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] r_wait_cnt;
    logic          r_rsp_err;
`endif

    always_ff @(posedge clk) begin : fsm
        if (rst) begin
            r_state      <= IDLE;
            r_last_grant <= GW'(N_REQ - 1);
            r_grant      <= '0;
            r_mul_a      <= '0;
            r_mul_b      <= '0;
            r_mul_en     <= 1'b0;
            r_rsp_valid  <= '0;
            r_rsp_q      <= '0;
`ifdef MULT_ARB_TIMEOUT_EN
            r_wait_cnt   <= '0;
            r_rsp_err    <= 1'b0;
`endif
        end else begin
            r_mul_en <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_grant      <= w_pick;
                        r_last_grant <= w_pick;
                        r_mul_a      <= req_a[16*w_pick +: 16];
                        r_mul_b      <= req_b[16*w_pick +: 16];
                        r_state      <= CLR;
                    end
                end
                CLR: begin
                    // mul_en is registered, so raising it here makes it
                    // high exactly during LOAD.
                    r_mul_en <= 1'b1;
                    r_state  <= LOAD;
                end
                LOAD: begin
`ifdef MULT_ARB_TIMEOUT_EN
                    r_wait_cnt <= '0;
`endif
                    r_state <= WAIT;
                end
                WAIT: begin
                    if (mul_flag) begin
                        r_rsp_q     <= mul_q;
                        r_rsp_valid <= w_grant_oh;
                        r_state     <= RESP;
`ifdef MULT_ARB_TIMEOUT_EN
                        r_rsp_err   <= 1'b0;
                    end else if (r_wait_cnt == CW'(TIMEOUT - 1)) begin
                        // Counter value c means c+1 WAIT cycles have elapsed.
                        r_rsp_q     <= '0;
                        r_rsp_err   <= 1'b1;
                        r_rsp_valid <= w_grant_oh;
                        r_state     <= RESP;
                    end else begin
                        r_wait_cnt  <= r_wait_cnt + 1'b1;
`endif
                    end
                end
                RESP: begin
                    if (rsp_ready[r_grant]) begin
                        r_rsp_valid <= '0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign rsp_valid   = r_rsp_valid;
    assign rsp_q       = r_rsp_q;
    assign mul_a       = r_mul_a;
    assign mul_b       = r_mul_b;
    assign mul_en      = r_mul_en;
    assign mul_rst     = rst | (r_state == CLR);
    assign o_dbg_state = r_state;
`ifdef MULT_ARB_TIMEOUT_EN
    assign rsp_err     = r_rsp_err;
`else
    assign rsp_err     = 1'b0;
`endif

endmodule

// File: tb/tb_mult_arbiter.sv
// tb_mult_arbiter: self-checking bench for mult_arbiter. Contains a timed
// model of the external multiplier, a requester-side model that predicts
// round-robin grants and products arithmetically, a vector table, directed
// multi-cycle sequences and randomized transactions.
module tb_mult_arbiter;
    localparam int N        = 4;
    localparam int LAT      = 21;   // accept cycle -> rsp_valid
    localparam int MUL_DONE = 18;   // flag appears 18 cycles after the load edge

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req_valid, req_ready, rsp_valid, rsp_ready;
    logic [16*N-1:0]  req_a, req_b;
    logic [31:0]      rsp_q, mul_q;
    logic             rsp_err, mul_en, mul_rst, mul_flag;
    logic [15:0]      mul_a, mul_b;
    logic [2:0]       dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    logic [N-1:0]     pending;
    logic [15:0]      op_a [N];
    logic [15:0]      op_b [N];
    int               last_m;
    logic [31:0]      exp_q [$];

    logic             m_busy = 1'b0;
    logic             m_stall = 1'b0;
    int               m_cnt = 0;
    logic [31:0]      m_prod = '0;

    typedef struct {
        int           hold;
        bit           noise;
        logic [N-1:0] add_mask;
        int           add_t;
        int           unstall_t;
        int           lat;
        bit           err;
        int           rst_t;
        bit           use_fixed;
        logic [31:0]  fixed_q;
        bit           churn;
    } cfg_t;

    typedef struct {
        int          idx;
        logic [15:0] a;
        logic [15:0] b;
        int          hold;
        logic [31:0] q;
    } vec_t;

    mult_arbiter #(.N_REQ(N), .TIMEOUT(40)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_q(rsp_q), .rsp_err(rsp_err),
        .mul_a(mul_a), .mul_b(mul_b), .mul_en(mul_en), .mul_rst(mul_rst),
        .mul_flag(mul_flag), .mul_q(mul_q),
        .o_dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // External shift-add multiplier: cleared by mul_rst, loaded by mul_en,
    // sticky done flag; m_stall freezes its progress.
    always @(posedge clk) begin
        if (mul_rst) begin
            mul_flag <= 1'b0;
            m_busy   <= 1'b0;
            m_cnt    <= 0;
        end else if (mul_en) begin
            m_busy   <= 1'b1;
            m_cnt    <= 1;
            mul_flag <= 1'b0;
            m_prod   <= $signed({{16{mul_a[15]}}, mul_a}) * $signed({{16{mul_b[15]}}, mul_b});
        end else if (m_busy && !m_stall) begin
            m_cnt <= m_cnt + 1;
            if (m_cnt + 1 == MUL_DONE) begin
                mul_flag <= 1'b1;
                m_busy   <= 1'b0;
            end
        end
    end
    assign mul_q = m_prod;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    function automatic int model_grant(input logic [N-1:0] p, input int last);
        for (int k = 1; k <= N; k++) begin
            if (p[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [31:0] model_prod(input logic [15:0] a, input logic [15:0] b);
        return 32'(int'($signed(a)) * int'($signed(b)));
    endfunction

    function automatic cfg_t base_cfg();
        cfg_t c;
        c.hold = 0; c.noise = 1'b0; c.add_mask = '0; c.add_t = -1;
        c.unstall_t = -1; c.lat = LAT; c.err = 1'b0; c.rst_t = -1;
        c.use_fixed = 1'b0; c.fixed_q = '0; c.churn = 1'b0;
        return c;
    endfunction

    task automatic drive(input logic [N-1:0] rdy);
        req_valid = pending;
        for (int i = 0; i < N; i++) begin
            req_a[16*i +: 16] = op_a[i];
            req_b[16*i +: 16] = op_b[i];
        end
        rsp_ready = rdy;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive('0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        last_m = N - 1;
        exp_q.delete();
    endtask

    // One transaction from grant to result handshake (or to a reset).
    // Entered and left just after a rising edge.
    task automatic run_txn(input cfg_t c, output int g);
        int acc_t, rv_t, eg;
        bit done, rdy_g;
        logic [N-1:0] rdy, oh;
        logic [15:0] la, lb;
        logic [31:0] eq;
        g = -1; acc_t = 0; rv_t = -1; done = 1'b0;
        la = '0; lb = '0; eq = '0; oh = '0;
        for (int t = 0; t < 250 && !done; t++) begin
            if (t == c.add_t) pending = pending | c.add_mask;
            if (c.churn && g >= 0 && $urandom_range(0, 3) == 0) begin
                int i;
                i = $urandom_range(0, N - 1);
                if (pending[i]) pending[i] = 1'b0;
                else begin
                    pending[i] = 1'b1;
                    op_a[i] = 16'($urandom);
                    op_b[i] = 16'($urandom);
                end
            end
            if (t == c.unstall_t) m_stall = 1'b0;
            rdy_g = (c.hold == 0) || (rv_t >= 0 && t - rv_t >= c.hold);
            rdy = '0;
            if (c.noise) rdy = N'($urandom);
            if (g >= 0) rdy[g] = rdy_g;
            if (t == c.rst_t) rst = 1'b1;
            drive(rdy);
            #1;
            if (t == c.rst_t) begin
                @(posedge clk);
                #1;
                check("rst_req_ready", 32'(req_ready), 32'(0));
                check("rst_rsp_valid", 32'(rsp_valid), 32'(0));
                check("rst_rsp_q", rsp_q, 32'(0));
                check("rst_rsp_err", 32'(rsp_err), 32'(0));
                check("rst_mul_en", 32'(mul_en), 32'(0));
                check("rst_mul_a", 32'(mul_a), 32'(0));
                check("rst_mul_b", 32'(mul_b), 32'(0));
                check("rst_mul_rst", 32'(mul_rst), 32'(1));
                rst = 1'b0;
                last_m = N - 1;
                exp_q.delete();
                done = 1'b1;
            end else begin
                if (g < 0) begin
                    eg = model_grant(pending, last_m);
                    oh = '0;
                    if (eg >= 0) oh[eg] = 1'b1;
                    check("grant", 32'(req_ready), 32'(oh));
                    check("idle_mul_rst", 32'(mul_rst), 32'(0));
                    if (eg < 0 || req_ready == '0) begin
                        done = 1'b1;
                    end else begin
                        g = eg; acc_t = t; last_m = eg;
                        la = op_a[g]; lb = op_b[g];
                        exp_q.push_back(c.use_fixed ? c.fixed_q : model_prod(la, lb));
                        pending[g] = 1'b0;
                    end
                end else begin
                    check("req_ready_low", 32'(req_ready), 32'(0));
                    check("mul_rst", 32'(mul_rst), 32'(t == acc_t + 1));
                    check("mul_en", 32'(mul_en), 32'(t == acc_t + 2));
                    if (rv_t < 0) begin
                        if (rsp_valid != '0) begin
                            rv_t = t;
                            check("latency", t - acc_t, c.lat);
                            check("rsp_valid", 32'(rsp_valid), 32'(oh));
                            if (exp_q.size() > 0) eq = exp_q.pop_front();
                            check("rsp_q", rsp_q, eq);
                            check("rsp_err", 32'(rsp_err), 32'(c.err));
                        end else begin
                            check("mul_a_hold", 32'(mul_a), 32'(la));
                            check("mul_b_hold", 32'(mul_b), 32'(lb));
                        end
                    end else begin
                        check("rsp_valid_hold", 32'(rsp_valid), 32'(oh));
                        check("rsp_q_hold", rsp_q, eq);
                    end
                    if (rv_t >= 0 && rdy_g) done = 1'b1;
                end
                @(posedge clk);
                #1;
            end
        end
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL txn_timeout: got no handshake expected one at %0t", $time);
        end
    endtask

    vec_t tab [6];
    int   order [5];

    initial begin
        cfg_t c;
        int g;

        tab[0] = '{0, 16'd3,     16'hFFFB, 0, 32'hFFFFFFF1};
        tab[1] = '{1, 16'h8000,  16'h8000, 0, 32'h40000000};
        tab[2] = '{2, 16'h7FFF,  16'h7FFF, 3, 32'h3FFF0001};
        tab[3] = '{3, 16'h8000,  16'h7FFF, 1, 32'hC0008000};
        tab[4] = '{0, 16'd0,     16'hFB2E, 0, 32'h00000000};
        tab[5] = '{1, 16'hFFFF,  16'hFFFF, 2, 32'h00000001};
        order  = '{0, 1, 2, 3, 0};

        pending = '0;
        for (int i = 0; i < N; i++) begin
            op_a[i] = '0;
            op_b[i] = '0;
        end

        // Reset state, with a request present to show it is not accepted.
        rst = 1'b1;
        pending = 4'b0010;
        drive('0);
        repeat (3) @(posedge clk);
        #1;
        check("reset_req_ready", 32'(req_ready), 32'(0));
        check("reset_rsp_valid", 32'(rsp_valid), 32'(0));
        check("reset_rsp_q", rsp_q, 32'(0));
        check("reset_rsp_err", 32'(rsp_err), 32'(0));
        check("reset_mul_en", 32'(mul_en), 32'(0));
        check("reset_mul_a", 32'(mul_a), 32'(0));
        check("reset_mul_b", 32'(mul_b), 32'(0));
        check("reset_mul_rst", 32'(mul_rst), 32'(1));
        rst = 1'b0;
        last_m = N - 1;
        pending = '0;

        // Vector table: single requester, fixed expected product.
        for (int i = 0; i < 6; i++) begin
            pending = '0;
            pending[tab[i].idx] = 1'b1;
            op_a[tab[i].idx] = tab[i].a;
            op_b[tab[i].idx] = tab[i].b;
            c = base_cfg();
            c.hold = tab[i].hold;
            c.use_fixed = 1'b1;
            c.fixed_q = tab[i].q;
            run_txn(c, g);
            check("tab_grant", g, tab[i].idx);
        end

        // All four requesting continuously: grant order 0,1,2,3,0.
        do_reset();
        for (int i = 0; i < N; i++) begin
            op_a[i] = 16'(i + 1);
            op_b[i] = 16'd100;
        end
        pending = '1;
        for (int k = 0; k < 5; k++) begin
            c = base_cfg();
            c.add_mask = '1;
            c.add_t = 1;
            c.use_fixed = 1'b1;
            c.fixed_q = 32'(100 * (order[k] + 1));
            run_txn(c, g);
            check("rr_order", g, order[k]);
        end

        // Requester 2 at the negative extreme; requester 1 arrives mid-WAIT
        // and must wait for the handshake.
        pending = 4'b0100;
        op_a[2] = 16'h8000; op_b[2] = 16'h8000;
        op_a[1] = 16'd7;    op_b[1] = 16'hFFF7;
        c = base_cfg();
        c.add_mask = 4'b0010;
        c.add_t = 6;
        c.use_fixed = 1'b1;
        c.fixed_q = 32'h40000000;
        run_txn(c, g);
        check("ext_grant", g, 2);

        // Requester 1 holds rsp_ready low for 10 RESP cycles while others
        // request; noise on the other rsp_ready bits.
        c = base_cfg();
        c.hold = 10;
        c.noise = 1'b1;
        c.add_mask = 4'b1001;
        c.add_t = 15;
        c.use_fixed = 1'b1;
        c.fixed_q = 32'hFFFFFFC1;
        run_txn(c, g);
        check("hold_grant", g, 1);

        // Randomized traffic against the model.
        for (int k = 0; k < 40; k++) begin
            if (pending == '0) begin
                int i;
                i = $urandom_range(0, N - 1);
                pending[i] = 1'b1;
                op_a[i] = ($urandom_range(0, 3) == 0) ? 16'h8000 : 16'($urandom);
                op_b[i] = ($urandom_range(0, 3) == 0) ? 16'h7FFF : 16'($urandom);
            end
            c = base_cfg();
            c.hold = $urandom_range(0, 4);
            c.noise = 1'b1;
            c.churn = 1'b1;
            run_txn(c, g);
        end

        // Multiplier never finishes (or finishes late).
        pending = 4'b0001;
        op_a[0] = 16'd9; op_b[0] = 16'd11;
        m_stall = 1'b1;
        c = base_cfg();
`ifdef MULT_ARB_TIMEOUT_EN
        c.lat = 43;
        c.err = 1'b1;
        c.use_fixed = 1'b1;
        c.fixed_q = 32'h0;
`else
        c.unstall_t = 60;
        c.lat = 78;
`endif
        run_txn(c, g);
        m_stall = 1'b0;

        // Reset in WAIT aborts; requester 0 wins first afterwards.
        pending = 4'b0100;
        op_a[2] = 16'd5; op_b[2] = 16'd6;
        c = base_cfg();
        c.add_mask = '1;
        c.add_t = 5;
        c.rst_t = 10;
        run_txn(c, g);
        c = base_cfg();
        run_txn(c, g);
        check("post_reset_grant", g, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: got no end of test expected one");
        $fatal(1, "simulation time limit");
    end

endmodule

// File: doc/mult_arbiter.md
MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 Parameters (name, default, meaning): N_REQ, 4, number of requesters; TIMEOUT, 40, watchdog limit in WAIT cycles.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 req_valid  input  N_REQ  per-requester operation request.
REQ-005 req_a  input  16*N_REQ  signed operand A; requester i uses bits [16i+15:16i].
REQ-006 req_b  input  16*N_REQ  signed operand B; same packing as req_a.
REQ-007 req_ready  output  N_REQ  one-hot accept strobe.
REQ-008 rsp_valid  output  N_REQ  one-hot result valid, addressed to the granted requester.
REQ-009 rsp_ready  input  N_REQ  per-requester result acceptance.
REQ-010 rsp_q  output  32  signed product.
REQ-011 rsp_err  output  1  watchdog abort flag, qualified by rsp_valid.
REQ-012 mul_a, mul_b  output  16 each  operands driven to the shared shift-add multiplier.
REQ-013 mul_en  output  1  multiplier load enable.
REQ-014 mul_rst  output  1  multiplier clear.
REQ-015 mul_flag  input  1  multiplier done flag, sticky until mul_rst.
REQ-016 mul_q  input  32  multiplier product.

Function
REQ-017 FSM states SHALL be IDLE, CLR, LOAD, WAIT, RESP.
REQ-018 IDLE: if any req_valid is high, grant one requester by round-robin, latch its operands, pulse req_ready[g] for that cycle only, and go to CLR.
REQ-019 Round-robin search SHALL start at last_grant+1, wrap modulo N_REQ, and update last_grant to g on each grant.
REQ-020 CLR: mul_rst=1 for exactly one cycle, then go to LOAD.
REQ-021 LOAD: mul_en=1 for exactly one cycle with the latched operands on mul_a/mul_b, then go to WAIT.
REQ-022 mul_a/mul_b SHALL hold the latched operands from CLR through WAIT.
REQ-023 WAIT: on mul_flag=1, register mul_q into rsp_q, set rsp_err=0, and go to RESP.
REQ-024 RESP: hold rsp_valid[g]=1 and rsp_q stable until rsp_ready[g]=1, then go to IDLE.
REQ-025 The earliest next grant SHALL be the cycle after the RESP handshake.
REQ-026 req_ready SHALL be low in every state except the IDLE grant cycle.
REQ-027 A requester deasserting req_valid before it is granted SHALL be legal; it is not latched.
REQ-028 Latency: rsp_valid rises 21 cycles after the accept cycle, given the 16-iteration multiplier.
REQ-029 Arithmetic: operands pass through unmodified; signed product range is -2^30+2^15 .. 2^30.
REQ-030 rsp_ready on non-granted bits SHALL be ignored.

Reset
REQ-031 On rst: state=IDLE, last_grant=N_REQ-1 (requester 0 wins first), req_ready=0, rsp_valid=0, rsp_q=0, rsp_err=0, mul_en=0, mul_a=mul_b=0.
REQ-032 mul_rst SHALL equal rst OR (state==CLR).
REQ-033 rst asserted mid-operation SHALL abort the operation and discard the result, with no rsp_valid issued.

Configuration
REQ-034 With MULT_ARB_TIMEOUT_EN defined, a WAIT cycle counter reset on WAIT entry SHALL force RESP with rsp_q=0 and rsp_err=1 once the counter reaches TIMEOUT with no mul_flag.
REQ-035 Without MULT_ARB_TIMEOUT_EN, WAIT SHALL wait indefinitely, rsp_err SHALL be tied 0, and no counter SHALL be instantiated.

Verification
REQ-036 Requester 0 only, a=3, b=-5, rsp_ready held high -> rsp_valid[0] at accept+21, rsp_q=-15 (32'hFFFFFFF1), rsp_err=0.
REQ-037 Requesters 0-3 all valid continuously, a=i+1, b=100 -> grant order 0,1,2,3,0; products 100,200,300,400.
REQ-038 Requester 2 issues a=-32768, b=-32768 while requester 1 requests mid-WAIT -> rsp_q=32'h40000000; req_ready[1] stays low until after the RESP handshake.
REQ-039 rsp_ready[1] held low 10 cycles in RESP -> rsp_valid[1] and rsp_q stable for those cycles; no new grant occurs.
REQ-040 rst pulsed in WAIT -> next cycle: all outputs 0 and mul_rst=1; after rst, requester 0 is granted first.
REQ-041 MULT_ARB_TIMEOUT_EN defined and mul_flag forced 0 -> rsp_valid at WAIT entry+40 with rsp_err=1, rsp_q=0.
